uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer (9-bit frames, send/ready interface) among NUM_REQ independent message sources, e.g. per-runway or per-aircraft reply generators.
- Round-robin grant; accepted word is captured locally so the requester is released immediately.
- The block sequences the serializer: one-cycle send pulse, then holds until the frame completes.
- Sits between the request-generating logic and uart_tx, all in the single clock domain.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding, the
// serializer payload width and a helper for index widths.
package uart_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_WAIT   = 2'd3
    } arb_state_e;

    // Payload width of the uart_tx serializer data port.
    localparam int UART_DATA_W = 9;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker. Scans the valid vector starting at the
// pointer and wrapping; the first valid index wins. With prio_en_i set,
// requester 0 wins whenever it is valid, regardless of the pointer.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               prio_en_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               found_o
);

    logic [ID_W-1:0] idx_s;

    // First valid requester at or after the pointer, with requester-0 override.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s    = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            winner_o = (!found_o && valid_i[idx_s]) ? idx_s : winner_o;
            found_o  = found_o | valid_i[idx_s];
        end
        // valid_i[0] high already implies found_o, so only the index moves.
        winner_o = (prio_en_i && valid_i[0]) ? '0 : winner_o;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ message sources. A winning
// word is captured locally (requester released by a one-cycle accept),
// then the serializer gets a one-cycle send pulse and the arbiter holds
// until the serializer reports idle again.
// Optional build macro: UART_ARB_PRIORITY_EN -- requester 0 gets absolute
// priority and its grants do not advance the round-robin pointer.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_accept,
    output logic                       uart_send,
    output logic [DATA_W-1:0]          uart_data,
    input  logic                       uart_ready,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id
);

`ifdef UART_ARB_PRIORITY_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  accept_q, accept_d;
    logic                send_q, send_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;

    logic [ID_W-1:0]     winner_s;
    logic                found_s;
    logic [DATA_W-1:0]   sel_data_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid_i   (req_valid),
        .ptr_i     (ptr_q),
        .prio_en_i (PRIO_EN),
        .winner_o  (winner_s),
        .found_o   (found_s)
    );

    // Select the winning requester's word from the packed data bus.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = (winner_s == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
        end
    end

    // Next-state and registered-output decode for the grant/issue/wait sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        accept_d = '0;
        send_d   = 1'b0;
        data_d   = data_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s && uart_ready) begin
                    accept_d = NUM_REQ'(1'b1) << winner_s;
                    data_d   = sel_data_s;
                    grant_d  = winner_s;
                    busy_d   = 1'b1;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                send_d  = 1'b1;
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                // Serializer ready is low while send is high; do not trust it here.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (uart_ready) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (PRIO_EN && (grant_q == '0)) begin
                        ptr_d = ptr_q;
                    end else if (grant_q == ID_W'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_q + ID_W'(1'b1);
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any word in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            accept_q <= '0;
            send_q   <= 1'b0;
            data_q   <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            accept_q <= accept_d;
            send_q   <= send_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign req_accept = accept_q;
    assign uart_send  = send_q;
    assign uart_data  = data_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes the expected grant
// order into a queue, a negedge monitor pops and checks accepts, the send
// pulse, data stability during the frame and the busy release.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 9;
    localparam int IW    = 2;
    localparam int FRAME = 6;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_accept;
    logic            uart_send;
    logic [DW-1:0]   uart_data;
    logic            uart_ready;
    logic            busy;
    logic [IW-1:0]   grant_id;

    logic [DW-1:0]   word [N];
    int              pending [N];
    logic            ser_hold = 1'b0;
    int              ser_cnt;

    exp_t            exp_q [$];
    exp_t            inflight;
    logic            send_due = 1'b0;
    logic            in_frame = 1'b0;

    int              tests = 0;
    int              fails = 0;

    assign req_data   = {word[3], word[2], word[1], word[0]};
    assign uart_ready = (ser_cnt == 0) && !uart_send && !ser_hold;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_accept (req_accept),
        .uart_send  (uart_send),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clock = ~clock;

    // Serializer model: busy for FRAME cycles after a send pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           ser_cnt <= 0;
        else if (uart_send)  ser_cnt <= FRAME;
        else if (ser_cnt > 0) ser_cnt <= ser_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT activity against the expected-grant queue.
    always @(negedge clock) begin
        if (reset) begin
            send_due = 1'b0;
            in_frame = 1'b0;
        end else begin
            if (req_accept != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", 32'(req_accept), 32'h0);
                end else begin
                    inflight = exp_q.pop_front();
                    check("accept_onehot", 32'(req_accept), 32'(4'b0001 << inflight.id));
                    check("accept_grant_id", 32'(grant_id), 32'(inflight.id));
                    check("accept_busy", 32'(busy), 32'h1);
                    send_due = 1'b1;
                end
            end else if (send_due) begin
                check("send_pulse", 32'(uart_send), 32'h1);
                check("send_data", 32'(uart_data), 32'(inflight.data));
                send_due = 1'b0;
                in_frame = 1'b1;
            end else if (uart_send) begin
                check("unexpected_send", 32'(uart_send), 32'h0);
            end else if (in_frame) begin
                check("frame_data_stable", 32'(uart_data), 32'(inflight.data));
                check("frame_grant_id", 32'(grant_id), 32'(inflight.id));
                if (!busy) begin
                    check("busy_release_ready", 32'(uart_ready), 32'h1);
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic apply_valid();
        for (int i = 0; i < N; i++) req_valid[i] = (pending[i] > 0);
    endtask

    // One clock; requesters consume an accept and drop valid when exhausted.
    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_accept[i] && pending[i] > 0) pending[i]--;
        end
        apply_valid();
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id   = IW'(id);
        e.data = word[id];
        exp_q.push_back(e);
    endtask

    task automatic run_until_quiet(input string name, input int budget);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while ((exp_q.size() != 0 || busy || req_valid != '0) && c < budget);
        if (c >= budget) check({name, "_timeout"}, 32'(c), 32'(budget - 1));
        step();
        step();
    endtask

    task automatic wait_send(input int budget);
        int c;
        c = 0;
        while (!uart_send && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) check("wait_send_timeout", 32'(c), 32'(budget - 1));
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) pending[i] = 0;
        apply_valid();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        word[0] = 9'h011; word[1] = 9'h122; word[2] = 9'h033; word[3] = 9'h144;
        for (int i = 0; i < N; i++) pending[i] = 0;
        do_reset();

        // Reset values
        check("rst_accept", 32'(req_accept), 32'h0);
        check("rst_send", 32'(uart_send), 32'h0);
        check("rst_data", 32'(uart_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);

        // Single request from requester 2
        word[2] = 9'h1A5;
        pending[2] = 1;
        push(2);
        apply_valid();
        run_until_quiet("single", 40);

        // Contention from reset
        do_reset();
        word[2] = 9'h033;
        pending[0] = 2; pending[1] = 1; pending[2] = 1; pending[3] = 1;
`ifdef UART_ARB_PRIORITY_EN
        push(0); push(0); push(1); push(2); push(3);
`else
        push(0); push(1); push(2); push(3); push(0);
`endif
        apply_valid();
        run_until_quiet("contention", 120);

        // Serializer not ready in IDLE
        do_reset();
        ser_hold = 1'b1;
        pending[0] = 1;
        push(0);
        apply_valid();
        for (int i = 0; i < 8; i++) begin
            step();
            check("hold_no_accept", 32'(req_accept), 32'h0);
            check("hold_not_busy", 32'(busy), 32'h0);
        end
        ser_hold = 1'b0;
        step();
        check("hold_release_accept", 32'(req_accept), 32'h1);
        run_until_quiet("hold", 40);

        // uart_data stability while requester data changes mid-frame
        do_reset();
        word[0] = 9'h0C3;
        pending[0] = 1;
        push(0);
        apply_valid();
        wait_send(10);
        step();
        word[0] = 9'h13C;
        run_until_quiet("stability", 40);

        // Reset during WAIT: pointer must return to 0
        do_reset();
        word[0] = 9'h0A0; word[1] = 9'h1B1; word[2] = 9'h0C2; word[3] = 9'h1D3;
        pending[1] = 1;
        push(1);
        apply_valid();
        run_until_quiet("pre_abort", 40);
        pending[2] = 1;
        push(2);
        apply_valid();
        wait_send(10);
        step();
        reset = 1'b1;
        #1;
        check("abort_accept", 32'(req_accept), 32'h0);
        check("abort_send", 32'(uart_send), 32'h0);
        check("abort_data", 32'(uart_data), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_grant", 32'(grant_id), 32'h0);
        exp_q.delete();
        pending[0] = 1; pending[2] = 0; pending[3] = 1;
        apply_valid();
        push(0); push(3);
        step();
        step();
        reset = 1'b0;
        run_until_quiet("post_abort", 60);

`ifdef UART_ARB_PRIORITY_EN
        // Requester 0 priority, then 1,2,3 from the preserved pointer
        do_reset();
        pending[0] = 3; pending[1] = 1; pending[2] = 1; pending[3] = 1;
        push(0); push(0); push(0); push(1); push(2); push(3);
        apply_valid();
        run_until_quiet("priority", 150);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
